// File: rtl/slice_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : slice_frame_pkg
// Description : Shared constants and types for the slice frame controller.
// Revision    : 1.0 - initial release
// ============================================================================
package slice_frame_pkg;

    localparam int LANES = 64;
    localparam int W     = 25;
    localparam int AW    = 6;

    typedef logic [AW:0] cnt7_t;

    localparam cnt7_t c_LANES_CNT = cnt7_t'(LANES);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_UNLOAD = 3'd3,
        ST_FIN    = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/slice_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : slice_frame_ctrl_if
// Description : Host load/unload streams plus encoder memory port.
// Revision    : 1.0 - initial release
// ============================================================================
interface slice_frame_ctrl_if;
    import slice_frame_pkg::*;

    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           enc_start;
    logic           enc_done;
    cnt7_t          enc_cnt;
    logic [W-1:0]   enc_line;
    logic           enc_wr_en;
    logic [W-1:0]   enc_wr_val;

    // master: host and encoder side; slave: the controller
    modport master (
        output in_valid, in_data, out_ready, enc_done, enc_cnt, enc_wr_en, enc_wr_val,
        input  in_ready, out_valid, out_data, enc_start, enc_line
    );

    modport slave (
        input  in_valid, in_data, out_ready, enc_done, enc_cnt, enc_wr_en, enc_wr_val,
        output in_ready, out_valid, out_data, enc_start, enc_line
    );

endinterface
`default_nettype wire

// File: rtl/lane_ram.sv
`default_nettype none
// ============================================================================
// Module      : lane_ram
// Description : Lane storage, one synchronous write port, one async read port.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_ram
    import slice_frame_pkg::*;
#(
    parameter int DEPTH  = LANES,
    parameter int WIDTH  = W,
    parameter int AWIDTH = AW
) (
    input  wire                 clk,
    input  wire                 i_we,
    input  wire  [AWIDTH-1:0]   i_waddr,
    input  wire  [WIDTH-1:0]    i_wdata,
    input  wire  [AWIDTH-1:0]   i_raddr,
    output logic [WIDTH-1:0]    o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/slice_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : slice_frame_ctrl
// Description : Loads a 64-lane frame, serves the encoder, unloads its result.
// Revision    : 1.0 - initial release
// ============================================================================
module slice_frame_ctrl
    import slice_frame_pkg::*;
(
    input  wire                 clk,
    input  wire                 rst,
    slice_frame_ctrl_if.slave   bus,
    output logic                busy,
    output logic                frame_done,
    output logic                overflow
);

    localparam logic [2:0] c_IDLE   = ST_IDLE;
    localparam logic [2:0] c_LOAD   = ST_LOAD;
    localparam logic [2:0] c_RUN    = ST_RUN;
    localparam logic [2:0] c_UNLOAD = ST_UNLOAD;
    localparam logic [2:0] c_FIN    = ST_FIN;

    localparam logic [AW-1:0] c_LAST_LANE = AW'(LANES - 1);

    logic [2:0]     r_state;
    logic [AW-1:0]  r_ld_ptr;
    cnt7_t          r_wr_cnt;
    cnt7_t          r_rd_ptr;
    logic           r_done_q;
    logic           r_overflow;

    logic           w_run;
    logic           w_unload;
    logic           w_in_hs;
    logic           w_out_hs;
    logic           w_cap;
    logic           w_drop;
    logic           w_done_rise;
    cnt7_t          w_wr_cnt_nxt;
    logic [AW-1:0]  w_enc_raddr;
    logic [W-1:0]   w_in_rdata;
    logic [W-1:0]   w_out_rdata;
    logic           w_unused;

    assign w_run    = (r_state == c_RUN);
    assign w_unload = (r_state == c_UNLOAD);

    assign bus.in_ready = rst && ((r_state == c_IDLE) || (r_state == c_LOAD));
    assign w_in_hs      = bus.in_valid && bus.in_ready;
    assign w_out_hs     = w_unload && bus.out_ready;

    assign w_cap        = w_run && bus.enc_wr_en && (r_wr_cnt < c_LANES_CNT);
    assign w_drop       = w_run && bus.enc_wr_en && (r_wr_cnt == c_LANES_CNT);
    assign w_wr_cnt_nxt = r_wr_cnt + cnt7_t'(w_cap);
    assign w_done_rise  = w_run && bus.enc_done && !r_done_q;

    // Prefetch one lane ahead; the 6-bit wrap makes lane 63 serve lane 0
    assign w_enc_raddr  = bus.enc_cnt[AW-1:0] + AW'(1);
    assign w_unused     = bus.enc_cnt[AW];

    lane_ram u_in_mem (
        .clk     (clk),
        .i_we    (w_in_hs),
        .i_waddr (r_ld_ptr),
        .i_wdata (bus.in_data),
        .i_raddr (w_enc_raddr),
        .o_rdata (w_in_rdata)
    );

    lane_ram u_out_mem (
        .clk     (clk),
        .i_we    (w_cap),
        .i_waddr (r_wr_cnt[AW-1:0]),
        .i_wdata (bus.enc_wr_val),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_out_rdata)
    );

    assign bus.enc_start = w_run;
    assign bus.enc_line  = w_run ? w_in_rdata : '0;
    assign bus.out_valid = w_unload;
    assign bus.out_data  = w_unload ? w_out_rdata : '0;
    assign busy          = (r_state != c_IDLE);
    assign frame_done    = (r_state == c_FIN);
    assign overflow      = r_overflow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_ld_ptr   <= '0;
            r_wr_cnt   <= '0;
            r_rd_ptr   <= '0;
            r_done_q   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            // Tracks enc_done in every state so a level held from before RUN is no edge
            r_done_q <= bus.enc_done;
            case (r_state)
                c_IDLE: begin
                    if (w_in_hs) begin
                        r_ld_ptr   <= AW'(1);
                        r_wr_cnt   <= '0;
                        r_rd_ptr   <= '0;
                        r_overflow <= 1'b0;
                        r_state    <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    if (w_in_hs) begin
                        r_ld_ptr <= r_ld_ptr + AW'(1);
                        if (r_ld_ptr == c_LAST_LANE) begin
                            r_state <= c_RUN;
                        end
                    end
                end
                c_RUN: begin
                    r_wr_cnt <= w_wr_cnt_nxt;
                    if (w_drop) begin
                        r_overflow <= 1'b1;
                    end
                    if (w_done_rise) begin
                        r_state <= (w_wr_cnt_nxt != '0) ? c_UNLOAD : c_FIN;
                    end
                end
                c_UNLOAD: begin
                    if (w_out_hs) begin
                        r_rd_ptr <= r_rd_ptr + cnt7_t'(1);
                        if (r_rd_ptr == (r_wr_cnt - cnt7_t'(1))) begin
                            r_state <= c_FIN;
                        end
                    end
                end
                c_FIN: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/slice_frame_ctrl.md
# slice_frame_ctrl

Host-side frame controller that services the column-parity encoder's memory interface. It accepts one 64-lane frame of 25-bit slices from a host stream and starts the encoder. While the encoder runs, it answers the encoder's lane reads and captures the encoder's lane writes. On encoder done it streams the captured result frame back to the host, which replaces the file-based memory model used around the encoder today.

## Interface
Parameters:
- LANES, 64, lanes per frame
- W, 25, lane width in bits (5x5 slice)
- AW, 6, lane address width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- in_valid  in  1  host load word valid
- in_ready  out  1  controller accepts load word
- in_data  in  W  load word, lane order 0..63
- out_valid  out  1  result word valid
- out_ready  in  1  host accepts result word
- out_data  out  W  result word, capture order
- enc_start  out  1  encoder start, level
- enc_done  in  1  encoder done (`donee`), may stay high
- enc_cnt  in  7  encoder lane counter (`cnt_value`)
- enc_line  out  W  lane served to encoder (`line_in`)
- enc_wr_en  in  1  encoder write strobe, one cycle per lane
- enc_wr_val  in  W  encoder write data
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse, frame fully unloaded
- overflow  out  1  sticky, more than LANES writes captured in the current frame

## Operation
- The FSM has five states: IDLE, LOAD, RUN, UNLOAD, FIN.
- IDLE: in_ready=1. The first in handshake writes in_mem[0] and moves to LOAD. It also clears overflow, wr_cnt and rd_ptr.
- LOAD: in_ready=1. Each handshake writes in_mem[ld_ptr] and increments ld_ptr. The handshake at ld_ptr=63 moves to RUN.
- RUN: enc_start=1 and in_ready=0.
  - enc_line = in_mem[(enc_cnt+1) mod 64], read combinationally. Only the low 6 bits of the sum are used, so the read prefetches one lane ahead and enc_cnt=63 serves lane 0.
  - Each cycle with enc_wr_en=1 and wr_cnt<64 writes out_mem[wr_cnt] and increments wr_cnt (7-bit, saturates at 64).
  - Each cycle with enc_wr_en=1 and wr_cnt=64 drops the word and sets overflow.
- RUN exit: detect a rising edge of enc_done against a registered copy.
  - wr_cnt>0: go to UNLOAD.
  - wr_cnt=0: go to FIN.
  - If enc_wr_en coincides with the edge cycle, that word is captured before the exit.
- UNLOAD: out_valid=1 and out_data=out_mem[rd_ptr] (first-word fall-through). Each out handshake increments rd_ptr. The handshake at rd_ptr=wr_cnt-1 moves to FIN.
- FIN: frame_done=1 for one cycle, then go to IDLE.
- Outside RUN: enc_wr_en and enc_done edges are ignored and enc_line=0.
- Outside UNLOAD: out_data=0.
- Reset, at any time including mid-frame:
  - State goes to IDLE; all pointers and counters are 0.
  - overflow=0, enc_start=0, out_valid=0, frame_done=0.
  - in_ready is forced to 0 while rst=0.
  - Memory contents are not reset.

## Timing
- enc_start rises on the first clock after the 64th load handshake. It falls on the clock after the enc_done rising edge is seen.
- out_valid rises 1 cycle after the enc_done rising edge, with the first word valid on that cycle.
- Full-throughput unload with out_ready held at 1: 64 cycles, then frame_done in the following cycle.
- Minimum load time is 64 cycles. Host backpressure on either stream stalls only that stream's pointer.
- enc_line depends combinationally on enc_cnt. The encoder samples it on the clock edge after enc_cnt changes.
- enc_done already high on RUN entry counts as no edge; the controller waits for low then high.

## Structure
- Package slice_frame_pkg holds:
  - LANES, W, AW constants
  - state enum (IDLE, LOAD, RUN, UNLOAD, FIN)
  - 7-bit counter type
- Sub-module lane_ram: LANES x W storage, one synchronous write port, one combinational read port.
  - Instantiated twice, as in_mem and out_mem.
  - Has no reset.
- The FSM, pointers, enc_done edge register and overflow flag live in slice_frame_ctrl.

## Test plan
- Full frame: load lanes i = i+1 (lane 63 = 64). Encoder model writes each served line XOR 25'h1555555, 64 writes, then raises done. Required: out_data[k] = (k+1) ^ 25'h1555555 for k = 0..63, 64 out handshakes, frame_done 1 cycle later, busy=0.
- Prefetch wrap: in RUN, drive enc_cnt = 0, 62, 63. Required: enc_line = lane 1, lane 63, lane 0.
- Overflow: encoder issues 66 writes. Required: the first 64 are captured, overflow=1 and stays set through UNLOAD, and clears on the next frame's first load handshake.
- Backpressure and edges: toggle out_ready 1,0,0,1 in UNLOAD. Required: out_data holds while stalled and no word is skipped or repeated. Assert enc_wr_en in the same cycle as the enc_done rise. Required: that word is the last word unloaded.
- Reset mid-run: pull rst low after the encoder's 10th write. Required: all outputs take their reset values immediately and in_ready=0 during reset. After release, a new full frame completes correctly with wr_cnt starting at 0.
- Zero writes: enc_done rises with no writes. Required: out_valid never asserts and frame_done pulses 1 cycle after the edge.
